// File: rtl/ldpc_term_ctrl.sv
// rtl/ldpc_term_ctrl.sv - LDPC decoder iteration/termination controller
module ldpc_term_ctrl #(
    parameter int ROWS_R12 = 256,
    parameter int ROWS_R34 = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rate,
    input  logic        start,
    input  logic [5:0]  max_iter,
    input  logic        en_in,
    input  logic [17:0] syn_in,
    output logic        iter_go,
    output logic        busy,
    output logic        done,
    output logic        converged,
    output logic [5:0]  iter_cnt,
    output logic [12:0] err_rows
);

    typedef enum logic [1:0] {IDLE, RUN, EVAL, DONE} state_t;

    // Row counter value of the final beat of an iteration for each rate.
    localparam logic [7:0] LAST_R12 = 8'(ROWS_R12 - 1);
    localparam logic [7:0] LAST_R34 = 8'(ROWS_R34 - 1);

    state_t      state_q, state_d;
    logic        rate_q, rate_d;
    logic [5:0]  max_q, max_d;
    logic [7:0]  row_cnt_q, row_cnt_d;
    logic        fail_flag_q, fail_flag_d;
    logic [12:0] err_acc_q, err_acc_d;
    logic        iter_go_q, iter_go_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        converged_q, converged_d;
    logic [5:0]  iter_cnt_q, iter_cnt_d;
    logic [12:0] err_rows_q, err_rows_d;

    logic [7:0]  last_row;
    logic [5:0]  iter_next;
    logic [4:0]  syn_pop;

    // Number of unsatisfied checks in one syndrome beat (0..18).
    function automatic logic [4:0] popcnt18(input logic [17:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 18; i++) begin
            c = c + {4'b0, v[i]};
        end
        return c;
    endfunction

    assign last_row  = rate_q ? LAST_R34 : LAST_R12;
    assign iter_next = iter_cnt_q + 6'd1;
    assign syn_pop   = popcnt18(syn_in);

    // Next-state and next-output logic for the termination FSM.
    always_comb begin
        state_d     = state_q;
        rate_d      = rate_q;
        max_d       = max_q;
        row_cnt_d   = row_cnt_q;
        fail_flag_d = fail_flag_q;
        err_acc_d   = err_acc_q;
        iter_go_d   = 1'b0;
        busy_d      = busy_q;
        done_d      = 1'b0;
        converged_d = converged_q;
        iter_cnt_d  = iter_cnt_q;
        err_rows_d  = err_rows_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rate_d      = rate;
                    // A zero limit would never terminate on failure; run one pass instead.
                    max_d       = (max_iter == 6'd0) ? 6'd1 : max_iter;
                    iter_cnt_d  = '0;
                    converged_d = 1'b0;
                    err_rows_d  = '0;
                    row_cnt_d   = '0;
                    fail_flag_d = 1'b0;
                    err_acc_d   = '0;
                    iter_go_d   = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                if (en_in) begin
                    row_cnt_d   = row_cnt_q + 8'd1;
                    fail_flag_d = fail_flag_q | (|syn_in);
                    err_acc_d   = err_acc_q + {8'b0, syn_pop};
                    if (row_cnt_q == last_row) begin
                        state_d = EVAL;
                    end
                end
            end
            EVAL: begin
                iter_cnt_d = iter_next;
                err_rows_d = err_acc_q;
                if (!fail_flag_q) begin
                    converged_d = 1'b1;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else if (iter_next == max_q) begin
                    converged_d = 1'b0;
                    done_d      = 1'b1;
                    state_d     = DONE;
                end else begin
                    row_cnt_d   = '0;
                    fail_flag_d = 1'b0;
                    err_acc_d   = '0;
                    iter_go_d   = 1'b1;
                    state_d     = RUN;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rate_q      <= 1'b0;
            max_q       <= '0;
            row_cnt_q   <= '0;
            fail_flag_q <= 1'b0;
            err_acc_q   <= '0;
            iter_go_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
            iter_cnt_q  <= '0;
            err_rows_q  <= '0;
        end else begin
            state_q     <= state_d;
            rate_q      <= rate_d;
            max_q       <= max_d;
            row_cnt_q   <= row_cnt_d;
            fail_flag_q <= fail_flag_d;
            err_acc_q   <= err_acc_d;
            iter_go_q   <= iter_go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            converged_q <= converged_d;
            iter_cnt_q  <= iter_cnt_d;
            err_rows_q  <= err_rows_d;
        end
    end

    assign iter_go   = iter_go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign converged = converged_q;
    assign iter_cnt  = iter_cnt_q;
    assign err_rows  = err_rows_q;

endmodule

// File: tb/tb_ldpc_term_ctrl.sv
// tb/tb_ldpc_term_ctrl.sv - randomized self-checking bench for ldpc_term_ctrl
module tb_ldpc_term_ctrl;

    logic        clk;
    logic        reset;
    logic        rate;
    logic        start;
    logic [5:0]  max_iter;
    logic        en_in;
    logic [17:0] syn_in;
    logic        iter_go;
    logic        busy;
    logic        done;
    logic        converged;
    logic [5:0]  iter_cnt;
    logic [12:0] err_rows;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int go_cnt   = 0;
    int done_cnt = 0;
    int it_mode [1:64];

    ldpc_term_ctrl #(.ROWS_R12(256), .ROWS_R34(128)) dut (
        .clk(clk), .reset(reset), .rate(rate), .start(start),
        .max_iter(max_iter), .en_in(en_in), .syn_in(syn_in),
        .iter_go(iter_go), .busy(busy), .done(done),
        .converged(converged), .iter_cnt(iter_cnt), .err_rows(err_rows)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle.
    always @(negedge clk) begin
        if (iter_go) go_cnt <= go_cnt + 1;
        if (done)    done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vec_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Syndrome for one beat given the iteration's stimulus mode.
    function automatic logic [17:0] gen_syn(input int mode, input int b);
        case (mode)
            1:       return (b == 0) ? 18'h00003 : 18'h0;
            2:       return (b < 20) ? 18'h00003 : 18'h0;
            3:       return ($urandom_range(0, 15) == 0) ? 18'($urandom) : 18'h0;
            4:       return 18'($urandom);
            default: return 18'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One codeword: drive beats, predict each iteration's outcome from the stimulus.
    task automatic run_cw(input logic r, input logic [5:0] mi, input int abort_it,
                          input int abort_beat, input bit junk);
        int rows, eff, go0, done0, acc, it, w;
        bit fail, fin;
        logic [17:0] s;
        rows  = r ? 128 : 256;
        eff   = (mi == 0) ? 1 : int'(mi);
        go0   = go_cnt;
        done0 = done_cnt;
        if (junk) begin
            en_in = 1'b1; syn_in = 18'h3ffff;
            tick();
            en_in = 1'b0; syn_in = '0;
        end
        rate = r; max_iter = mi; start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        fin = 0;
        it  = 0;
        while (!fin) begin
            it++;
            w = 0;
            while (!iter_go && w < 8) begin
                tick();
                w++;
            end
            chk("iter_go_seen", iter_go, 1);
            acc  = 0;
            fail = 0;
            for (int b = 0; b < rows; b++) begin
                if ($urandom_range(0, 7) == 0) begin
                    en_in = 1'b0;
                    if (junk) begin
                        start = 1'b1; rate = ~r; max_iter = 6'($urandom);
                    end
                    tick();
                    start = 1'b0;
                end
                if (it == abort_it && b == abort_beat) begin
                    reset = 1'b1;
                    #1;
                    chk("rst_iter_go", iter_go, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_converged", converged, 0);
                    chk("rst_iter_cnt", iter_cnt, 0);
                    chk("rst_err_rows", err_rows, 0);
                    en_in = 1'b0; syn_in = '0;
                    tick();
                    tick();
                    reset = 1'b0;
                    chk("abort_no_done", done_cnt - done0, 0);
                    return;
                end
                s    = gen_syn(it_mode[it], b);
                acc += $countones(s);
                fail = fail | (s != 18'h0);
                en_in = 1'b1; syn_in = s;
                tick();
            end
            en_in = 1'b0; syn_in = '0;
            chk("eval_no_done", done, 0);
            chk("eval_busy", busy, 1);
            if (junk) begin
                en_in = 1'b1; syn_in = 18'h3ffff; start = 1'b1;
            end
            tick();
            en_in = 1'b0; syn_in = '0; start = 1'b0;
            fin = !fail || (it == eff);
            chk("iter_cnt", iter_cnt, it);
            chk("err_rows", err_rows, acc);
            if (fin) begin
                chk("done", done, 1);
                chk("converged", converged, !fail);
                chk("busy_in_done", busy, 1);
                chk("iter_go_in_done", iter_go, 0);
                if (junk) begin
                    en_in = 1'b1; syn_in = 18'h3ffff;
                end
                tick();
                en_in = 1'b0; syn_in = '0;
                chk("done_cleared", done, 0);
                chk("busy_cleared", busy, 0);
                chk("held_converged", converged, !fail);
                chk("held_iter_cnt", iter_cnt, it);
                chk("held_err_rows", err_rows, acc);
                chk("iter_go_count", go_cnt - go0, it);
                chk("done_count", done_cnt - done0, 1);
            end else begin
                chk("iter_go_pulse", iter_go, 1);
                chk("no_early_done", done, 0);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; rate = 1'b0; start = 1'b0; max_iter = '0;
        en_in = 1'b0; syn_in = '0;
        for (int i = 1; i <= 64; i++) it_mode[i] = 0;
        #2;
        chk("reset_busy", busy, 0);
        chk("reset_iter_cnt", iter_cnt, 0);
        chk("reset_err_rows", err_rows, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // A: clean first pass at rate 1/2
        for (int i = 1; i <= 64; i++) it_mode[i] = 0;
        run_cw(1'b0, 6'd5, 0, 0, 0);
        chk("A_converged", converged, 1);
        chk("A_iter_cnt", iter_cnt, 1);
        chk("A_err_rows", err_rows, 0);

        // B: one 2-bit failure every iteration, hits the limit
        for (int i = 1; i <= 64; i++) it_mode[i] = 1;
        run_cw(1'b1, 6'd3, 0, 0, 0);
        chk("B_converged", converged, 0);
        chk("B_iter_cnt", iter_cnt, 3);
        chk("B_err_rows", err_rows, 2);

        // C: 40 failing bits, then clean
        for (int i = 1; i <= 64; i++) it_mode[i] = 0;
        it_mode[1] = 2;
        run_cw(1'b0, 6'd10, 0, 0, 0);
        chk("C_converged", converged, 1);
        chk("C_iter_cnt", iter_cnt, 2);
        chk("C_err_rows", err_rows, 0);

        // D: zero limit behaves as one
        for (int i = 1; i <= 64; i++) it_mode[i] = 4;
        run_cw(1'b1, 6'd0, 0, 0, 0);
        chk("D_converged", converged, 0);
        chk("D_iter_cnt", iter_cnt, 1);

        // E: test B again with stray start/en_in everywhere they must be ignored
        for (int i = 1; i <= 64; i++) it_mode[i] = 1;
        run_cw(1'b1, 6'd3, 0, 0, 1);
        chk("E_converged", converged, 0);
        chk("E_iter_cnt", iter_cnt, 3);
        chk("E_err_rows", err_rows, 2);

        // F: reset at beat 100 of iteration 2, then immediate fresh start
        for (int i = 1; i <= 64; i++) it_mode[i] = 4;
        run_cw(1'b0, 6'd5, 2, 100, 0);
        for (int i = 1; i <= 64; i++) it_mode[i] = 0;
        run_cw(1'b1, 6'd4, 0, 0, 0);
        chk("F_converged", converged, 1);
        chk("F_iter_cnt", iter_cnt, 1);

        // Randomized codewords
        for (int n = 0; n < 8; n++) begin
            for (int i = 1; i <= 64; i++) begin
                it_mode[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 4));
            end
            run_cw(1'($urandom), 6'($urandom_range(0, 4)), 0, 0, bit'($urandom));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/ldpc_term_ctrl.md
LDPC_TERM_CTRL -- requirements
Module: ldpc_term_ctrl

Parameters
REQ-001 The module SHALL have parameter ROWS_R12, default 256, giving the number of en_in beats per iteration at rate=0 (4608 rows / 18).
REQ-002 The module SHALL have parameter ROWS_R34, default 128, giving the number of en_in beats per iteration at rate=1 (2304 rows / 18).

Interface
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port rate, input, 1 bit: code rate, 0 = 1/2, 1 = 3/4; sampled on start accept.
REQ-006 The module SHALL have port start, input, 1 bit: one-cycle pulse that begins decoding control for one codeword.
REQ-007 The module SHALL have port max_iter, input, 6 bits: iteration limit; sampled on start accept; 0 is treated as 1.
REQ-008 The module SHALL have port en_in, input, 1 bit: syndrome beat valid; driven by the check-processor array en_out.
REQ-009 The module SHALL have port syn_in, input, 18 bits: one parity flag per check processor; 1 = check unsatisfied.
REQ-010 The module SHALL have port iter_go, output, 1 bit: one-cycle pulse requesting the array to run the next iteration.
REQ-011 The module SHALL have port busy, output, 1 bit: high from start accept until the done pulse, inclusive.
REQ-012 The module SHALL have port done, output, 1 bit: one-cycle pulse at termination.
REQ-013 The module SHALL have port converged, output, 1 bit: 1 = the last iteration had every check satisfied.
REQ-014 The module SHALL have port iter_cnt, output, 6 bits: the number of completed iterations.
REQ-015 The module SHALL have port err_rows, output, 13 bits: count of failed checks in the last completed iteration.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, EVAL and DONE, all registered, and every output SHALL be driven from a register.
REQ-017 In IDLE, start=1 SHALL latch rate and max_iter, clear iter_cnt, converged, err_rows, row_cnt, fail_flag and err_acc, pulse iter_go on the next cycle, and enter RUN.
REQ-018 A start asserted in any state other than IDLE SHALL be ignored.
REQ-019 In RUN, each en_in=1 cycle SHALL do three things: increment row_cnt; OR the reduction-OR of syn_in into fail_flag; add popcount(syn_in), a value from 0 to 18, to err_acc. err_acc is 13 bits and does not saturate; its maximum is 4608.
REQ-020 In RUN, the cycle with en_in=1 and row_cnt = ROWS-1, where ROWS is selected by the latched rate, SHALL include that beat and then move the FSM to EVAL.
REQ-021 en_in SHALL be ignored in IDLE, EVAL and DONE, and no beat SHALL be counted there.
REQ-022 In EVAL, lasting exactly 1 cycle, the block SHALL update iter_cnt to iter_cnt+1 and err_rows to err_acc.
REQ-023 In EVAL, if fail_flag=0, the block SHALL set converged to 1 and go to DONE.
REQ-024 In EVAL, if fail_flag=1 and iter_cnt+1 equals the effective max_iter, the block SHALL set converged to 0 and go to DONE.
REQ-025 In EVAL, in any other case, the block SHALL clear row_cnt, fail_flag and err_acc, pulse iter_go in the next cycle, and return to RUN.
REQ-026 The first en_in beat of a new iteration SHALL be accepted in the same cycle as the iter_go pulse or in any later cycle.
REQ-027 In DONE, lasting exactly 1 cycle, the block SHALL assert done for that cycle, deassert busy on the following cycle, and return to IDLE.
REQ-028 converged, iter_cnt and err_rows SHALL hold their values in IDLE until the next start is accepted.
REQ-029 Latency SHALL be: last beat of an iteration → EVAL on the next cycle → done or iter_go on the cycle after that, i.e. 2 cycles.
REQ-030 row_cnt SHALL be 8 bits and SHALL never wrap within an iteration, because the transition to EVAL occurs at ROWS-1.

Reset
REQ-031 Asserting reset SHALL force, with no clock required: state=IDLE; iter_go=0; busy=0; done=0; converged=0; iter_cnt=0; err_rows=0; all internal counters and flags=0.
REQ-032 Reset asserted mid-RUN SHALL abort the codeword, SHALL produce no done pulse, and the block SHALL accept a start in the first cycle after reset deasserts.

Verification
REQ-033 Test A: rate=0, max_iter=5, start, then 256 beats with syn_in=0 → one EVAL, then done with converged=1, iter_cnt=1, err_rows=0, and iter_go pulsed exactly once (after start).
REQ-034 Test B: rate=1, max_iter=3, every iteration has one beat with syn_in=18'h00003 → iter_go pulses 3 times in total, then done with converged=0, iter_cnt=3, err_rows=2.
REQ-035 Test C: rate=0, max_iter=10, iteration 1 beats total 40 failing bits and iteration 2 is all-zero → done after the 512th beat with converged=1, iter_cnt=2, err_rows=0.
REQ-036 Test D: max_iter=0 with failing syndromes → terminates after 1 iteration with converged=0 and iter_cnt=1.
REQ-037 Test E: start pulsed during RUN and en_in pulsed during IDLE/EVAL → both ignored, and row counts and results are unchanged versus the same run without them.
REQ-038 Test F: reset asserted at beat 100 of iteration 2 → all outputs read 0 immediately, and a fresh start with 128 clean beats at rate=1 yields converged=1 and iter_cnt=1.
